// File: rtl/pbuf_sched_pkg.sv
// -----------------------------------------------------------------------------
// pbuf_sched_pkg
// Shared definitions for the parameter-buffer scheduler: default geometry,
// drain length and the scheduler FSM state encoding.
// -----------------------------------------------------------------------------
package pbuf_sched_pkg;

    localparam int PBUF_ENTRIES = 512;   // parameter-buffer entries
    localparam int PBUF_TAG_W   = 12;    // primitive-tag width
    localparam int DRAIN_CYCLES = 2;     // cycles allowed for in-flight ops before scrub

    typedef enum logic [1:0] {
        RUN   = 2'd0,   // normal arbitration of writer/reader
        DRAIN = 2'd1,   // handshakes blocked, in-flight ops completing
        SCRUB = 2'd2    // zero-writing every entry
    } pbuf_state_e;

endpackage

// File: rtl/pbuf_rr_arb.sv
// -----------------------------------------------------------------------------
// pbuf_rr_arb
// Two-way round-robin arbiter between the writer and the reader. With a single
// requester it grants that side; with both it grants the side not granted
// last. After reset the writer wins the first conflict.
//
// Ports
//   clock, reset       : clock, asynchronous active-high reset
//   enable             : grants allowed this cycle (scheduler in RUN)
//   wr_valid, rd_valid : request lines
//   wr_grant, rd_grant : combinational, one-hot or zero
// -----------------------------------------------------------------------------
module pbuf_rr_arb (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic wr_valid,
    input  logic rd_valid,
    output logic wr_grant,
    output logic rd_grant
);

    // 1 when the reader should win the next conflict (writer was granted last).
    logic prefer_rd;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        wr_grant = 1'b0;
        rd_grant = 1'b0;
        if (enable) begin
            if (wr_valid && rd_valid) begin
                wr_grant = !prefer_rd;
                rd_grant = prefer_rd;
            end else begin
                wr_grant = wr_valid;
                rd_grant = rd_valid;
            end
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_rd <= 1'b0;
        end else if (wr_grant || rd_grant) begin
            prefer_rd <= wr_grant;
        end
    end

endmodule

// File: rtl/pbuf_sched.sv
// -----------------------------------------------------------------------------
// pbuf_sched
// Schedules writer stores and reader fetches onto a single-port parameter
// buffer, tracks a per-entry valid bitmap, and on a flush drains in-flight
// operations and scrubs every entry to zero.
//
// Optional build macro: PBUF_SCHED_STATS_EN adds 32-bit wrapping counters
// stat_wr, stat_rd, stat_miss, stat_conflict.
//
// Ports
//   clock, reset                 : clock, asynchronous active-high reset
//   wr_valid/wr_tag/wr_ready     : writer request, tag, combinational accept
//   rd_valid/rd_tag/rd_ready     : reader request, tag, combinational accept
//   flush                        : one-cycle scrub request (ignored while busy)
//   prim_tag, pcache_write       : registered buffer address / write strobe
//   pcache_zero                  : selects zero write-data during scrub
//   rd_resp_valid, rd_resp_hit   : fetch response two cycles after accept
//   err_oor                      : pulse, accepted tag >= ENTRIES
//   busy                         : drain or scrub in progress
// -----------------------------------------------------------------------------
module pbuf_sched
    import pbuf_sched_pkg::*;
#(
    parameter int ENTRIES = PBUF_ENTRIES,
    parameter int TAG_W   = PBUF_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_valid,
    input  logic [TAG_W-1:0] wr_tag,
    output logic             wr_ready,
    input  logic             rd_valid,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_ready,
    input  logic             flush,
    output logic [TAG_W-1:0] prim_tag,
    output logic             pcache_write,
    output logic             pcache_zero,
    output logic             rd_resp_valid,
    output logic             rd_resp_hit,
    output logic             err_oor,
    output logic             busy
`ifdef PBUF_SCHED_STATS_EN
    ,
    output logic [31:0]      stat_wr,
    output logic [31:0]      stat_rd,
    output logic [31:0]      stat_miss,
    output logic [31:0]      stat_conflict
`endif
);

    localparam int               IDX_W      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [TAG_W:0]   ENTRIES_X  = (TAG_W+1)'(ENTRIES);
    localparam logic [TAG_W-1:0] LAST_TAG   = TAG_W'(ENTRIES - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    pbuf_state_e      state;
    logic [1:0]       drain_cnt;
    logic [ENTRIES-1:0] valid_q;
    logic             rd_s1;       // read accepted last cycle
    logic             hit_s1;      // its valid bit, sampled at accept

    logic             run;
    logic             accept;
    logic [TAG_W-1:0] sel_tag;
    logic             sel_in_range;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;

    assign run = (state == RUN);

    pbuf_rr_arb u_arb (
        .clock    (clock),
        .reset    (reset),
        .enable   (run),
        .wr_valid (wr_valid),
        .rd_valid (rd_valid),
        .wr_grant (wr_ready),
        .rd_grant (rd_ready)
    );

    // Grants are one-hot, so the accepted tag is a simple select.
    assign accept       = wr_ready | rd_ready;
    assign sel_tag      = wr_ready ? wr_tag : rd_tag;
    assign sel_in_range = ({1'b0, sel_tag} < ENTRIES_X);
    assign sel_idx      = sel_tag[IDX_W-1:0];
    assign sel_valid    = sel_in_range & valid_q[sel_idx];

    // NOTE: the valid bitmap is a flop vector, not RAM, so it can and must be
    // reset; the buffer data itself lives outside and is cleared by the scrub.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= RUN;
            drain_cnt     <= '0;
            valid_q       <= '0;
            prim_tag      <= '0;
            pcache_write  <= 1'b0;
            pcache_zero   <= 1'b0;
            err_oor       <= 1'b0;
            busy          <= 1'b0;
            rd_s1         <= 1'b0;
            hit_s1        <= 1'b0;
            rd_resp_valid <= 1'b0;
            rd_resp_hit   <= 1'b0;
        end else begin
            // Response pipeline keeps running in DRAIN so in-flight reads finish.
            rd_s1         <= rd_ready;
            hit_s1        <= sel_valid;
            rd_resp_valid <= rd_s1;
            rd_resp_hit   <= rd_s1 & hit_s1;
            err_oor       <= accept & !sel_in_range;
            pcache_write  <= 1'b0;
            pcache_zero   <= 1'b0;

            case (state)
                RUN: begin
                    if (accept) begin
                        prim_tag     <= sel_tag;
                        pcache_write <= wr_ready & sel_in_range;
                        // Set now so a read of this tag next cycle reports a hit.
                        if (wr_ready && sel_in_range) begin
                            valid_q[sel_idx] <= 1'b1;
                        end
                    end
                    if (flush) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state        <= SCRUB;
                        prim_tag     <= '0;
                        pcache_write <= 1'b1;
                        pcache_zero  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end

                SCRUB: begin
                    // prim_tag doubles as the scrub address counter.
                    if (prim_tag == LAST_TAG) begin
                        state   <= RUN;
                        busy    <= 1'b0;
                        valid_q <= '0;
                    end else begin
                        prim_tag     <= prim_tag + TAG_W'(1);
                        pcache_write <= 1'b1;
                        pcache_zero  <= 1'b1;
                    end
                end

                default: state <= RUN;
            endcase
        end
    end

`ifdef PBUF_SCHED_STATS_EN
    // Free-running wrapping counters; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_wr       <= '0;
            stat_rd       <= '0;
            stat_miss     <= '0;
            stat_conflict <= '0;
        end else begin
            stat_wr       <= stat_wr + 32'(wr_ready);
            stat_rd       <= stat_rd + 32'(rd_ready);
            stat_miss     <= stat_miss + 32'(rd_ready & !sel_valid);
            stat_conflict <= stat_conflict + 32'(wr_valid & rd_valid);
        end
    end
`endif

endmodule
